// File: rtl/fetch_32.sv
// fetch_32: instruction fetch stage; PC, single-outstanding imem requests, and a FIFO toward decode.
// Optional feature macro FETCH_BYPASS_EN: a response that finds the FIFO empty is shown to decode in its arrival cycle.
module fetch_32 #(
  parameter int unsigned          REG_WIDTH  = 32,
  parameter logic [REG_WIDTH-1:0] RESET_PC   = '0,
  parameter int unsigned          FIFO_DEPTH = 2
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  output logic                 o_imem_valid,
  output logic [REG_WIDTH-1:0] o_imem_addr,
  input  logic                 i_imem_ready,
  input  logic                 i_imem_rvalid,
  input  logic [REG_WIDTH-1:0] i_imem_rdata,
  output logic                 o_valid,
  output logic [REG_WIDTH-1:0] o_instruction,
  output logic [REG_WIDTH-1:0] o_pc,
  input  logic                 i_stall,
  input  logic                 i_redirect,
  input  logic [REG_WIDTH-1:0] i_redirect_pc
);
  // state | meaning
  // IDLE  | no request; waiting for FIFO space
  // REQ   | request driven at the fetch PC
  // WAIT  | request accepted, response will be kept
  // DROP  | request accepted before a flush, response will be discarded
  typedef enum logic [1:0] {IDLE = 2'd0, REQ = 2'd1, WAIT = 2'd2, DROP = 2'd3} state_t;

  localparam int unsigned          PTR_W   = $clog2(FIFO_DEPTH);
  localparam int unsigned          CNT_W   = PTR_W + 1;
  localparam logic [CNT_W-1:0]     DEPTH_C = CNT_W'(FIFO_DEPTH);
  localparam logic [REG_WIDTH-1:0] PC_STEP = REG_WIDTH'(4);

  state_t               state_q;
  logic                 imem_valid_q;
  logic [REG_WIDTH-1:0] pc_q;
  logic [REG_WIDTH-1:0] req_pc_q;

  logic [REG_WIDTH-1:0] fifo_instr_q [FIFO_DEPTH];
  logic [REG_WIDTH-1:0] fifo_pc_q    [FIFO_DEPTH];
  logic [PTR_W-1:0]     wr_ptr_q;
  logic [PTR_W-1:0]     rd_ptr_q;
  logic [CNT_W-1:0]     count_q;
  logic [CNT_W-1:0]     count_d;

  logic                 accept;
  logic                 resp;
  logic                 fifo_empty;
  logic                 flush;
  logic                 bypass;
  logic                 push;
  logic                 pop;
  logic                 hold_outstanding;
  logic [REG_WIDTH-1:0] redirect_pc;

  always_comb begin
    accept      = imem_valid_q && i_imem_ready;
    resp        = (state_q == WAIT) && i_imem_rvalid;
    fifo_empty  = (count_q == '0);
    flush       = i_rst || i_redirect;
    redirect_pc = i_redirect_pc & ~REG_WIDTH'(3);
    // A flush must still absorb a response that is owed for an already-accepted request
    hold_outstanding = accept ||
                       (((state_q == WAIT) || (state_q == DROP)) && !i_imem_rvalid);
`ifdef FETCH_BYPASS_EN
    bypass = resp && fifo_empty && !flush;
`else
    bypass = 1'b0;
`endif
    pop     = !flush && !fifo_empty && !i_stall;
    push    = !flush && resp && !(bypass && !i_stall);
    count_d = count_q + CNT_W'(push) - CNT_W'(pop);

    o_valid       = 1'b0;
    o_instruction = '0;
    o_pc          = '0;
    if (!i_rst) begin
      if (!fifo_empty) begin
        o_valid       = 1'b1;
        o_instruction = fifo_instr_q[rd_ptr_q];
        o_pc          = fifo_pc_q[rd_ptr_q];
      end else if (bypass) begin
        o_valid       = 1'b1;
        o_instruction = i_imem_rdata;
        o_pc          = req_pc_q;
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (flush) begin
      pc_q <= i_rst ? RESET_PC : redirect_pc;
      if (hold_outstanding) begin
        state_q      <= DROP;
        imem_valid_q <= 1'b0;
      end else if (i_rst) begin
        state_q      <= IDLE;
        imem_valid_q <= 1'b0;
      end else begin
        state_q      <= REQ;
        imem_valid_q <= 1'b1;
      end
    end else begin
      case (state_q)
        IDLE: begin
          if (count_q < DEPTH_C) begin
            state_q      <= REQ;
            imem_valid_q <= 1'b1;
          end
        end
        REQ: begin
          if (accept) begin
            req_pc_q     <= pc_q;
            pc_q         <= pc_q + PC_STEP;
            state_q      <= WAIT;
            imem_valid_q <= 1'b0;
          end
        end
        WAIT: begin
          if (i_imem_rvalid) begin
            if (count_d < DEPTH_C) begin
              state_q      <= REQ;
              imem_valid_q <= 1'b1;
            end else begin
              state_q      <= IDLE;
              imem_valid_q <= 1'b0;
            end
          end
        end
        DROP: begin
          if (i_imem_rvalid) begin
            state_q      <= REQ;
            imem_valid_q <= 1'b1;
          end
        end
        default: begin
          state_q      <= IDLE;
          imem_valid_q <= 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge i_clk) begin
    if (flush) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) begin
        fifo_instr_q[wr_ptr_q] <= i_imem_rdata;
        fifo_pc_q[wr_ptr_q]    <= req_pc_q;
        wr_ptr_q               <= wr_ptr_q + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      end
      count_q <= count_d;
    end
  end

  assign o_imem_valid = imem_valid_q;
  assign o_imem_addr  = pc_q;

endmodule

// File: tb/tb_fetch_32.sv
// Testbench for fetch_32: memory model plus PC/instruction scoreboard, scenario tasks run in sequence.
module tb_fetch_32;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        imem_ready = 1'b1;
  logic        imem_rvalid = 1'b0;
  logic [31:0] imem_rdata = '0;
  logic        stall = 1'b0;
  logic        redirect = 1'b0;
  logic [31:0] redirect_pc = '0;
  logic        imem_valid;
  logic [31:0] imem_addr;
  logic        dut_valid;
  logic [31:0] dut_instr;
  logic [31:0] dut_pc;

  logic        ready2 = 1'b1;
  logic        rv2 = 1'b0;
  logic [31:0] rd2 = '0;
  logic        stall2 = 1'b0;
  logic        redir2 = 1'b0;
  logic [31:0] rpc2 = '0;
  logic        v2;
  logic [31:0] a2;
  logic        ov2;
  logic [31:0] oi2;
  logic [31:0] op2;

  int          total = 0;
  int          bad = 0;

  int          mem_lat = 1;
  bit          use_override = 1'b0;
  bit          pending = 1'b0;
  int          rem = 0;
  logic [31:0] pend_addr = '0;
  logic        next_rvalid = 1'b0;
  logic [31:0] next_rdata = '0;
  logic [31:0] exp_addr = '0;
  logic [63:0] exp_q [$];
  logic        mon_acc;
  logic [63:0] mon_e;
  logic        nrv2 = 1'b0;
  logic [31:0] nad2 = '0;

  fetch_32 dut (
    .i_clk(clk), .i_rst(rst),
    .o_imem_valid(imem_valid), .o_imem_addr(imem_addr), .i_imem_ready(imem_ready),
    .i_imem_rvalid(imem_rvalid), .i_imem_rdata(imem_rdata),
    .o_valid(dut_valid), .o_instruction(dut_instr), .o_pc(dut_pc),
    .i_stall(stall), .i_redirect(redirect), .i_redirect_pc(redirect_pc)
  );

  fetch_32 #(.RESET_PC(32'hFFFF_FFF8)) dut2 (
    .i_clk(clk), .i_rst(rst),
    .o_imem_valid(v2), .o_imem_addr(a2), .i_imem_ready(ready2),
    .i_imem_rvalid(rv2), .i_imem_rdata(rd2),
    .o_valid(ov2), .o_instruction(oi2), .o_pc(op2),
    .i_stall(stall2), .i_redirect(redir2), .i_redirect_pc(rpc2)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] memf(input logic [31:0] a);
    return a ^ 32'hA5A5_0000;
  endfunction

  // Memory responses change just after the rising edge
  always @(posedge clk) begin
    #1;
    imem_rvalid = next_rvalid;
    imem_rdata  = next_rdata;
    rv2         = nrv2;
    rd2         = nrv2 ? memf(nad2) : 32'h0;
  end

  // Negedge: inputs and outputs are settled; account for what the next edge will do
  always @(negedge clk) begin
    mon_acc = imem_valid && imem_ready;
    if (imem_rvalid) pending = 1'b0;
    else if (pending) rem = rem - 1;
    if (mon_acc) begin
      if (!rst) begin
        total++;
        if (pending) begin
          bad++;
          $display("FAIL single_outstanding: accept at %h while %h still unanswered", imem_addr, pend_addr);
        end
        total++;
        if (imem_addr !== exp_addr) begin
          bad++;
          $display("FAIL req_addr: got %h want %h", imem_addr, exp_addr);
        end
      end
      pending   = 1'b1;
      pend_addr = imem_addr;
      rem       = mem_lat;
    end
    next_rvalid = pending && (rem == 1);
    next_rdata  = !next_rvalid ? 32'h0 : (use_override ? 32'hDEAD_BEEF : memf(pend_addr));

    if (rst) begin
      exp_q.delete();
      exp_addr = 32'h0;
    end else if (redirect) begin
      exp_q.delete();
      exp_addr = {redirect_pc[31:2], 2'b00};
    end else begin
      if (mon_acc) begin
        exp_q.push_back({imem_addr, memf(imem_addr)});
        exp_addr = exp_addr + 32'd4;
      end
      if (dut_valid && !stall) begin
        total++;
        if (exp_q.size() == 0) begin
          bad++;
          $display("FAIL scoreboard_extra: got pc=%h instr=%h with nothing expected", dut_pc, dut_instr);
        end else begin
          mon_e = exp_q.pop_front();
          if ({dut_pc, dut_instr} !== mon_e) begin
            bad++;
            $display("FAIL scoreboard: got pc=%h instr=%h want pc=%h instr=%h",
                     dut_pc, dut_instr, mon_e[63:32], mon_e[31:0]);
          end
        end
      end
    end
    if (!dut_valid) begin
      total++;
      if (dut_pc !== 32'h0 || dut_instr !== 32'h0) begin
        bad++;
        $display("FAIL idle_zero: got pc=%h instr=%h want 0 0", dut_pc, dut_instr);
      end
    end

    nrv2 = v2 && ready2;
    if (v2 && ready2) nad2 = a2;
  end

  task automatic do_reset(input int n, input logic stall_v, input int lat_v);
    @(posedge clk); #1;
    rst = 1'b1; redirect = 1'b0; stall = stall_v; mem_lat = lat_v;
    repeat (n) @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic test_reset();
    repeat (3) @(posedge clk);
    @(negedge clk);
    total++;
    if (imem_valid !== 1'b0) begin bad++; $display("FAIL reset_imem_valid: got %b want 0", imem_valid); end
    total++;
    if (imem_addr !== 32'h0) begin bad++; $display("FAIL reset_imem_addr: got %h want 0", imem_addr); end
    total++;
    if (dut_valid !== 1'b0) begin bad++; $display("FAIL reset_valid: got %b want 0", dut_valid); end
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    @(negedge clk);
    total++;
    if (imem_valid !== 1'b1 || imem_addr !== 32'h0) begin
      bad++;
      $display("FAIL first_request: got valid=%b addr=%h want 1 0", imem_valid, imem_addr);
    end
  endtask

  task automatic test_stream();
    int found = 0;
    int cnt = 0;
    for (int i = 0; i < 10 && found == 0; i++) begin
      @(negedge clk);
      if (dut_valid) found = 1;
    end
    total++;
    if (found == 0) begin
      bad++;
      $display("FAIL stream_timeout: got no o_valid want one within 10 cycles");
    end else begin
      if (dut_pc !== 32'h0 || dut_instr !== 32'hA5A5_0000) begin
        bad++;
        $display("FAIL stream_first: got pc=%h instr=%h want 0 a5a50000", dut_pc, dut_instr);
      end
      cnt = 1;
      repeat (19) begin
        @(negedge clk);
        if (dut_valid) cnt++;
      end
      total++;
      if (cnt != 10) begin
        bad++;
        $display("FAIL stream_rate: got %0d valid in 20 cycles want 10", cnt);
      end
    end
  endtask

  task automatic test_stall();
    logic [31:0] got [3];
    int n = 0;
    do_reset(6, 1'b1, 1);
    repeat (10) begin
      @(negedge clk);
      if (dut_valid) begin
        total++;
        if (dut_pc !== 32'h0) begin bad++; $display("FAIL stall_head: got pc=%h want 0", dut_pc); end
      end
    end
    total++;
    if (imem_valid !== 1'b0 || dut_valid !== 1'b1) begin
      bad++;
      $display("FAIL stall_full: got imem_valid=%b valid=%b want 0 1", imem_valid, dut_valid);
    end
    @(posedge clk); #1;
    stall = 1'b0;
    repeat (12) begin
      @(negedge clk);
      if (dut_valid && !stall && n < 3) begin
        got[n] = dut_pc;
        n++;
      end
    end
    total++;
    if (n != 3) begin
      bad++;
      $display("FAIL stall_release_count: got %0d entries want 3", n);
    end else begin
      for (int i = 0; i < 3; i++) begin
        total++;
        if (got[i] !== 32'(4 * i)) begin
          bad++;
          $display("FAIL stall_order: entry %0d got pc=%h want %h", i, got[i], 32'(4 * i));
        end
      end
    end
  endtask

  task automatic test_redirect_drop();
    int found = 0;
    do_reset(6, 1'b0, 4);
    for (int i = 0; i < 40 && found == 0; i++) begin
      @(negedge clk);
      if (imem_valid && imem_ready && imem_addr == 32'h8) found = 1;
    end
    total++;
    if (found == 0) begin
      bad++;
      $display("FAIL drop_setup: got no accept of 8 want one within 40 cycles");
      return;
    end
    @(posedge clk); #1;
    redirect = 1'b1; redirect_pc = 32'h0000_0103; use_override = 1'b1;
    @(posedge clk); #1;
    redirect = 1'b0;
    @(negedge clk);
    total++;
    if (imem_valid !== 1'b0) begin bad++; $display("FAIL drop_hold: got imem_valid=%b want 0", imem_valid); end
    found = 0;
    for (int i = 0; i < 10 && found == 0; i++) begin
      @(negedge clk);
      if (imem_rvalid) begin found = 1; use_override = 1'b0; end
    end
    use_override = 1'b0;
    found = 0;
    for (int i = 0; i < 20 && found == 0; i++) begin
      @(negedge clk);
      if (dut_valid) found = 1;
    end
    total++;
    if (found == 0) begin
      bad++;
      $display("FAIL drop_timeout: got no o_valid want one within 20 cycles");
    end else if (dut_pc !== 32'h100 || dut_instr !== memf(32'h100)) begin
      bad++;
      $display("FAIL drop_first: got pc=%h instr=%h want 100 %h", dut_pc, dut_instr, memf(32'h100));
    end
  endtask

  task automatic test_redirect_pop();
    int found = 0;
    do_reset(6, 1'b1, 1);
    for (int i = 0; i < 10 && found == 0; i++) begin
      @(negedge clk);
      if (imem_rvalid) found = 1;
    end
    total++;
    if (found == 0) begin
      bad++;
      $display("FAIL rpop_setup: got no response want one within 10 cycles");
      return;
    end
    @(posedge clk); #1;
    @(posedge clk); #1;
    stall = 1'b0; redirect = 1'b1; redirect_pc = 32'h200;
    @(negedge clk);
    total++;
    if (imem_rvalid !== 1'b1 || dut_valid !== 1'b1) begin
      bad++;
      $display("FAIL rpop_precond: got rvalid=%b valid=%b want 1 1", imem_rvalid, dut_valid);
    end
    @(posedge clk); #1;
    redirect = 1'b0;
    @(negedge clk);
    total++;
    if (dut_valid !== 1'b0 || dut_pc !== 32'h0) begin
      bad++;
      $display("FAIL rpop_flushed: got valid=%b pc=%h want 0 0", dut_valid, dut_pc);
    end
    total++;
    if (imem_valid !== 1'b1 || imem_addr !== 32'h200) begin
      bad++;
      $display("FAIL rpop_retarget: got valid=%b addr=%h want 1 200", imem_valid, imem_addr);
    end
    found = 0;
    for (int i = 0; i < 10 && found == 0; i++) begin
      @(negedge clk);
      if (dut_valid) found = 1;
    end
    total++;
    if (found == 0 || dut_pc !== 32'h200) begin
      bad++;
      $display("FAIL rpop_first: got found=%0d pc=%h want 1 200", found, dut_pc);
    end
  endtask

  task automatic test_latency();
    int found = 0;
    do_reset(6, 1'b0, 1);
    for (int i = 0; i < 10 && found == 0; i++) begin
      @(negedge clk);
      if (imem_rvalid) found = 1;
    end
    total++;
    if (found == 0) begin
      bad++;
      $display("FAIL lat_setup: got no response want one within 10 cycles");
      return;
    end
`ifdef FETCH_BYPASS_EN
    total++;
    if (dut_valid !== 1'b1 || dut_pc !== 32'h0 || dut_instr !== 32'hA5A5_0000) begin
      bad++;
      $display("FAIL lat_bypass: got valid=%b pc=%h instr=%h want 1 0 a5a50000", dut_valid, dut_pc, dut_instr);
    end
`else
    total++;
    if (dut_valid !== 1'b0) begin
      bad++;
      $display("FAIL lat_same_cycle: got valid=%b want 0", dut_valid);
    end
    @(negedge clk);
    total++;
    if (dut_valid !== 1'b1 || dut_pc !== 32'h0) begin
      bad++;
      $display("FAIL lat_next_cycle: got valid=%b pc=%h want 1 0", dut_valid, dut_pc);
    end
`endif
  endtask

  task automatic test_wrap();
    logic [31:0] addrs [3];
    logic [31:0] want [3];
    logic [31:0] first_pc = '0;
    logic [31:0] first_instr = '0;
    int n = 0;
    int seen = 0;
    want[0] = 32'hFFFF_FFF8; want[1] = 32'hFFFF_FFFC; want[2] = 32'h0000_0000;
    do_reset(6, 1'b0, 1);
    repeat (20) begin
      @(negedge clk);
      if (v2 && n < 3) begin addrs[n] = a2; n++; end
      if (ov2 && seen == 0) begin first_pc = op2; first_instr = oi2; seen = 1; end
    end
    total++;
    if (n != 3) begin
      bad++;
      $display("FAIL wrap_count: got %0d requests want 3", n);
    end else begin
      for (int i = 0; i < 3; i++) begin
        total++;
        if (addrs[i] !== want[i]) begin
          bad++;
          $display("FAIL wrap_addr: request %0d got %h want %h", i, addrs[i], want[i]);
        end
      end
    end
    total++;
    if (seen == 0 || first_pc !== 32'hFFFF_FFF8 || first_instr !== memf(32'hFFFF_FFF8)) begin
      bad++;
      $display("FAIL wrap_decode: got seen=%0d pc=%h instr=%h want 1 fffffff8 %h",
               seen, first_pc, first_instr, memf(32'hFFFF_FFF8));
    end
  endtask

  initial begin
    test_reset();
    test_stream();
    test_stall();
    test_redirect_drop();
    test_redirect_pop();
    test_latency();
    test_wrap();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
